// File: rtl/parking_pkg.sv
// Shared constants and the reserved-capacity schedule for the car park controller.
package parking_pkg;

  typedef logic [4:0] hour_t;

  localparam int HOURS_PER_DAY   = 24;
  localparam int TOTAL_CAP_DEF   = 700;
  localparam int START_HOUR_DEF  = 8;
  localparam int RES_CAP_0_DEF   = 500;
  localparam int RES_HOUR_1_DEF  = 14;
  localparam int RES_HOUR_2_DEF  = 15;
  localparam int RES_HOUR_3_DEF  = 16;
  localparam int RES_CAP_1_DEF   = 450;
  localparam int RES_CAP_2_DEF   = 400;
  localparam int RES_CAP_3_DEF   = 200;

  // Reserved capacity in force at a given hour of the business day. Hours past
  // midnight but before the start hour still belong to the previous day's last step.
  function automatic int res_cap_for_hour(
    input hour_t hour,
    input int    start_hour = START_HOUR_DEF,
    input int    cap0       = RES_CAP_0_DEF,
    input int    h1         = RES_HOUR_1_DEF,
    input int    cap1       = RES_CAP_1_DEF,
    input int    h2         = RES_HOUR_2_DEF,
    input int    cap2       = RES_CAP_2_DEF,
    input int    h3         = RES_HOUR_3_DEF,
    input int    cap3       = RES_CAP_3_DEF
  );
    int h;
    h = int'(hour);
    if (h >= h3 || h < start_hour) return cap3;
    if (h >= h2) return cap2;
    if (h >= h1) return cap1;
    return cap0;
  endfunction

endpackage

// File: rtl/parking_hour_clock.sv
// Time-of-day keeper: divides the clock into hours and flags hour and day boundaries.
module parking_hour_clock import parking_pkg::*; #(
  parameter int unsigned CLOCKS_PER_HOUR = 500,
  parameter int unsigned START_HOUR      = START_HOUR_DEF
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  output hour_t hour_o,
  output hour_t hour_nxt_o,
  output logic  hour_tick_o,
  output logic  day_rollover_o
);

  localparam int TICK_W = (CLOCKS_PER_HOUR > 1) ? $clog2(CLOCKS_PER_HOUR) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLOCKS_PER_HOUR - 1);
  localparam hour_t LAST_HOUR  = hour_t'(HOURS_PER_DAY - 1);
  localparam hour_t START_H    = hour_t'(START_HOUR);

  logic [TICK_W-1:0] tick_q, tick_d;
  hour_t             hour_q, hour_d;

  // Hour boundary detection and next-state for tick and hour.
  always_comb begin
    hour_tick_o    = (tick_q == TICK_LAST);
    hour_nxt_o     = (hour_q == LAST_HOUR) ? '0 : hour_q + hour_t'(1);
    day_rollover_o = hour_tick_o && (hour_nxt_o == START_H);
    tick_d         = tick_q + TICK_W'(1);
    hour_d         = hour_q;
    if (hour_tick_o) begin
      tick_d = '0;
      hour_d = hour_nxt_o;
    end
  end

  // Tick and hour registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tick_q <= '0;
      hour_q <= START_H;
    end else begin
      tick_q <= tick_d;
      hour_q <= hour_d;
    end
  end

  assign hour_o = hour_q;

endmodule

// File: rtl/parking_multigate_ctrl.sv
// Two-class car park occupancy controller with parallel entry/exit gates and a
// time-of-day reserved-capacity schedule.
module parking_multigate_ctrl import parking_pkg::*; #(
  parameter int unsigned NUM_GATES       = 2,
  parameter int unsigned CNT_W           = 10,
  parameter int unsigned TOTAL_CAP       = TOTAL_CAP_DEF,
  parameter int unsigned CLOCKS_PER_HOUR = 500,
  parameter int unsigned START_HOUR      = START_HOUR_DEF,
  parameter int unsigned RES_CAP_0       = RES_CAP_0_DEF,
  parameter int unsigned RES_HOUR_1      = RES_HOUR_1_DEF,
  parameter int unsigned RES_HOUR_2      = RES_HOUR_2_DEF,
  parameter int unsigned RES_HOUR_3      = RES_HOUR_3_DEF,
  parameter int unsigned RES_CAP_1       = RES_CAP_1_DEF,
  parameter int unsigned RES_CAP_2       = RES_CAP_2_DEF,
  parameter int unsigned RES_CAP_3       = RES_CAP_3_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_GATES-1:0] entry_valid,
  input  logic [NUM_GATES-1:0] entry_is_res,
  input  logic [NUM_GATES-1:0] exit_valid,
  input  logic [NUM_GATES-1:0] exit_is_res,
  output logic [NUM_GATES-1:0] entry_grant,
  output logic [NUM_GATES-1:0] exit_grant,
  output logic [4:0]           hour,
  output logic [CNT_W-1:0]     res_parked,
  output logic [CNT_W-1:0]     gen_parked,
  output logic [CNT_W-1:0]     res_free,
  output logic [CNT_W-1:0]     gen_free,
  output logic                 res_has_space,
  output logic                 gen_has_space,
  output logic                 ja_nist,
  output logic                 faulty_exit
);

  localparam logic [CNT_W-1:0] TOTAL_C = CNT_W'(TOTAL_CAP);
  localparam logic [CNT_W-1:0] CAP0_C  = CNT_W'(RES_CAP_0);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  hour_t hour_nxt;
  logic  hour_tick;
  logic  day_rollover;

  parking_hour_clock #(
    .CLOCKS_PER_HOUR (CLOCKS_PER_HOUR),
    .START_HOUR      (START_HOUR)
  ) u_hour_clock (
    .clk_i          (clock),
    .rst_ni         (reset),
    .hour_o         (hour),
    .hour_nxt_o     (hour_nxt),
    .hour_tick_o    (hour_tick),
    .day_rollover_o (day_rollover)
  );

  logic [CNT_W-1:0]     res_parked_q, res_parked_d;
  logic [CNT_W-1:0]     gen_parked_q, gen_parked_d;
  logic [CNT_W-1:0]     res_cap_q, res_cap_d;
  logic [CNT_W-1:0]     new_cap;
  logic [CNT_W-1:0]     gen_cap;
  logic [NUM_GATES-1:0] entry_grant_q, entry_grant_d;
  logic [NUM_GATES-1:0] exit_grant_q, exit_grant_d;
  logic                 ja_nist_q, ja_nist_d;
  logic                 faulty_exit_q, faulty_exit_d;

  // Rollover/schedule first, then exits, then entries, each on the running counts.
  always_comb begin
    res_parked_d  = res_parked_q;
    gen_parked_d  = gen_parked_q;
    res_cap_d     = res_cap_q;
    entry_grant_d = '0;
    exit_grant_d  = '0;
    ja_nist_d     = 1'b0;
    faulty_exit_d = 1'b0;
    new_cap = CNT_W'(res_cap_for_hour(hour_nxt, int'(START_HOUR), int'(RES_CAP_0),
                                      int'(RES_HOUR_1), int'(RES_CAP_1),
                                      int'(RES_HOUR_2), int'(RES_CAP_2),
                                      int'(RES_HOUR_3), int'(RES_CAP_3)));

    if (day_rollover) begin
      res_parked_d = '0;
      gen_parked_d = '0;
      res_cap_d    = CAP0_C;
    end else if (hour_tick) begin
      // Reserved cars above the shrunken cap are reclassified as general; the
      // general cap grows by at least as much, so they always fit.
      if (res_parked_d > new_cap) begin
        gen_parked_d = gen_parked_d + (res_parked_d - new_cap);
        res_parked_d = new_cap;
      end
      res_cap_d = new_cap;
    end

    gen_cap = TOTAL_C - res_cap_d;

    for (int g = 0; g < int'(NUM_GATES); g++) begin
      if (exit_valid[g]) begin
        if (exit_is_res[g]) begin
          if (res_parked_d != '0) begin
            res_parked_d    = res_parked_d - ONE_C;
            exit_grant_d[g] = 1'b1;
          end else begin
            faulty_exit_d = 1'b1;
          end
        end else begin
          if (gen_parked_d != '0) begin
            gen_parked_d    = gen_parked_d - ONE_C;
            exit_grant_d[g] = 1'b1;
          end else begin
            faulty_exit_d = 1'b1;
          end
        end
      end
    end

    for (int g = 0; g < int'(NUM_GATES); g++) begin
      if (entry_valid[g]) begin
        if (entry_is_res[g]) begin
          if (res_parked_d < res_cap_d) begin
            res_parked_d     = res_parked_d + ONE_C;
            entry_grant_d[g] = 1'b1;
          end else begin
            ja_nist_d = 1'b1;
          end
        end else begin
          if (gen_parked_d < gen_cap) begin
            gen_parked_d     = gen_parked_d + ONE_C;
            entry_grant_d[g] = 1'b1;
          end else begin
            ja_nist_d = 1'b1;
          end
        end
      end
    end
  end

  // Occupancy, capacity, grant and pulse registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      res_parked_q  <= '0;
      gen_parked_q  <= '0;
      res_cap_q     <= CAP0_C;
      entry_grant_q <= '0;
      exit_grant_q  <= '0;
      ja_nist_q     <= 1'b0;
      faulty_exit_q <= 1'b0;
    end else begin
      res_parked_q  <= res_parked_d;
      gen_parked_q  <= gen_parked_d;
      res_cap_q     <= res_cap_d;
      entry_grant_q <= entry_grant_d;
      exit_grant_q  <= exit_grant_d;
      ja_nist_q     <= ja_nist_d;
      faulty_exit_q <= faulty_exit_d;
    end
  end

  assign entry_grant   = entry_grant_q;
  assign exit_grant    = exit_grant_q;
  assign ja_nist       = ja_nist_q;
  assign faulty_exit   = faulty_exit_q;
  assign res_parked    = res_parked_q;
  assign gen_parked    = gen_parked_q;
  assign res_free      = res_cap_q - res_parked_q;
  assign gen_free      = TOTAL_C - res_cap_q - gen_parked_q;
  assign res_has_space = (res_free != '0);
  assign gen_has_space = (gen_free != '0);

endmodule

// File: tb/tb_parking_multigate_ctrl.sv
// Self-checking bench for parking_multigate_ctrl with a cycle-count based occupancy model.
module tb_parking_multigate_ctrl;

  localparam int NG  = 2;
  localparam int CW  = 10;
  localparam int CPH = 500;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [NG-1:0] entry_valid = '0, entry_is_res = '0, exit_valid = '0, exit_is_res = '0;
  logic [NG-1:0] entry_grant, exit_grant;
  logic [4:0]    hour;
  logic [CW-1:0] res_parked, gen_parked, res_free, gen_free;
  logic          res_has_space, gen_has_space, ja_nist, faulty_exit;

  parking_multigate_ctrl dut (
    .clock(clock), .reset(reset),
    .entry_valid(entry_valid), .entry_is_res(entry_is_res),
    .exit_valid(exit_valid), .exit_is_res(exit_is_res),
    .entry_grant(entry_grant), .exit_grant(exit_grant), .hour(hour),
    .res_parked(res_parked), .gen_parked(gen_parked),
    .res_free(res_free), .gen_free(gen_free),
    .res_has_space(res_has_space), .gen_has_space(gen_has_space),
    .ja_nist(ja_nist), .faulty_exit(faulty_exit)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: time is just the number of clock edges since reset.
  int            m_n, m_res, m_gen, m_cap;
  logic [NG-1:0] m_eg, m_xg;
  logic          m_ja, m_fx;

  // Reserved cap by hours elapsed since the start of the business day (8h).
  function automatic int sched_cap(input int hs);
    if (hs < 6)  return 500;
    if (hs == 6) return 450;
    if (hs == 7) return 400;
    return 200;
  endfunction

  function automatic int m_hour();
    return (8 + m_n / CPH) % 24;
  endfunction

  task automatic model_reset();
    m_n = 0; m_res = 0; m_gen = 0; m_cap = 500;
    m_eg = '0; m_xg = '0; m_ja = 1'b0; m_fx = 1'b0;
  endtask

  task automatic model_edge(input logic [NG-1:0] ev, er, xv, xr);
    int hs, nc;
    m_n++;
    m_eg = '0; m_xg = '0; m_ja = 1'b0; m_fx = 1'b0;
    if (m_n % CPH == 0) begin
      hs = (m_n / CPH) % 24;
      if (hs == 0) begin
        m_res = 0; m_gen = 0; m_cap = 500;
      end else begin
        nc = sched_cap(hs);
        if (m_res > nc) begin
          m_gen += m_res - nc;
          m_res = nc;
        end
        m_cap = nc;
      end
    end
    for (int g = 0; g < NG; g++) begin
      if (xv[g]) begin
        if (xr[g] && m_res > 0)       begin m_res--; m_xg[g] = 1'b1; end
        else if (!xr[g] && m_gen > 0) begin m_gen--; m_xg[g] = 1'b1; end
        else m_fx = 1'b1;
      end
    end
    for (int g = 0; g < NG; g++) begin
      if (ev[g]) begin
        if (er[g] && m_res < m_cap)              begin m_res++; m_eg[g] = 1'b1; end
        else if (!er[g] && m_gen < 700 - m_cap)  begin m_gen++; m_eg[g] = 1'b1; end
        else m_ja = 1'b1;
      end
    end
  endtask

  // Drive one cycle of requests, advance the model, sample 1 time unit after the edge.
  task automatic step(input logic [NG-1:0] ev, er, xv, xr);
    entry_valid = ev; entry_is_res = er; exit_valid = xv; exit_is_res = xr;
    @(posedge clock);
    model_edge(ev, er, xv, xr);
    #1;
    entry_valid = '0; exit_valid = '0;
    entry_is_res = NG'($urandom); exit_is_res = NG'($urandom);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    #16;
    do_reset();
    n_checks++;
    if (hour !== 5'd8) $display("FAIL reset_hour: got %0d want 8", hour); else n_pass++;
    n_checks++;
    if (res_free !== 10'd500) $display("FAIL reset_res_free: got %0d want 500", res_free); else n_pass++;
    n_checks++;
    if (gen_free !== 10'd200) $display("FAIL reset_gen_free: got %0d want 200", gen_free); else n_pass++;
    n_checks++;
    if ({res_has_space, gen_has_space} !== 2'b11)
      $display("FAIL reset_has_space: got %b want 11", {res_has_space, gen_has_space}); else n_pass++;
    n_checks++;
    if ({entry_grant, exit_grant, ja_nist, faulty_exit} !== 6'b0)
      $display("FAIL reset_pulses: got %b want 000000", {entry_grant, exit_grant, ja_nist, faulty_exit});
    else n_pass++;
    step('0, '0, '0, '0);
    n_checks++;
    if ({res_parked, gen_parked} !== 20'd0)
      $display("FAIL reset_idle_counts: got %0d/%0d want 0/0", res_parked, gen_parked); else n_pass++;
  endtask

  task automatic test_faulty_exit();
    step('0, '0, 2'b01, 2'b00);
    n_checks++;
    if (exit_grant !== 2'b00 || faulty_exit !== 1'b1)
      $display("FAIL faulty_exit_gen: got grant=%b fx=%b want 00/1", exit_grant, faulty_exit); else n_pass++;
    n_checks++;
    if ({res_parked, gen_parked} !== 20'd0)
      $display("FAIL faulty_exit_counts: got %0d/%0d want 0/0", res_parked, gen_parked); else n_pass++;
    step('0, '0, '0, '0);
    n_checks++;
    if (faulty_exit !== 1'b0) $display("FAIL faulty_exit_pulse: got %b want 0", faulty_exit); else n_pass++;
  endtask

  task automatic test_fill_reserved();
    int bad = 0;
    for (int i = 0; i < 500; i++) begin
      step(2'b01, 2'b01, '0, '0);
      if (entry_grant !== 2'b01 || ja_nist !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL fill_grants: got %0d refused cycles want 0", bad); else n_pass++;
    n_checks++;
    if (res_parked !== 10'd500 || res_has_space !== 1'b0)
      $display("FAIL fill_full: got parked=%0d space=%b want 500/0", res_parked, res_has_space); else n_pass++;
    step(2'b01, 2'b01, '0, '0);
    n_checks++;
    if (entry_grant !== 2'b00 || ja_nist !== 1'b1)
      $display("FAIL fill_501st: got grant=%b ja=%b want 00/1", entry_grant, ja_nist); else n_pass++;
  endtask

  task automatic test_same_cycle_full();
    step(2'b01, 2'b01, 2'b10, 2'b10);
    n_checks++;
    if (entry_grant !== 2'b01 || exit_grant !== 2'b10 || ja_nist !== 1'b0 || faulty_exit !== 1'b0)
      $display("FAIL same_cycle_grants: got eg=%b xg=%b ja=%b fx=%b want 01/10/0/0",
               entry_grant, exit_grant, ja_nist, faulty_exit);
    else n_pass++;
    n_checks++;
    if (res_parked !== 10'd500) $display("FAIL same_cycle_parked: got %0d want 500", res_parked); else n_pass++;
  endtask

  task automatic test_contention();
    for (int i = 0; i < 199; i++) step(2'b01, 2'b00, '0, '0);
    n_checks++;
    if (gen_free !== 10'd1) $display("FAIL contention_setup: got gen_free=%0d want 1", gen_free); else n_pass++;
    step(2'b11, 2'b00, '0, '0);
    n_checks++;
    if (entry_grant !== 2'b01 || ja_nist !== 1'b1)
      $display("FAIL contention_grant: got eg=%b ja=%b want 01/1", entry_grant, ja_nist); else n_pass++;
    n_checks++;
    if (gen_free !== 10'd0 || gen_has_space !== 1'b0)
      $display("FAIL contention_free: got %0d/%b want 0/0", gen_free, gen_has_space); else n_pass++;
  endtask

  task automatic test_random(input int ncyc);
    logic [NG-1:0] ev, er, xv, xr;
    for (int i = 0; i < ncyc; i++) begin
      ev = NG'($urandom); er = NG'($urandom); xv = NG'($urandom); xr = NG'($urandom);
      step(ev, er, xv, xr);
      n_checks++;
      if ({entry_grant, exit_grant, ja_nist, faulty_exit} !== {m_eg, m_xg, m_ja, m_fx})
        $display("FAIL rand_pulses cyc %0d: got %b want %b", m_n,
                 {entry_grant, exit_grant, ja_nist, faulty_exit}, {m_eg, m_xg, m_ja, m_fx});
      else n_pass++;
      n_checks++;
      if (res_parked !== CW'(m_res) || gen_parked !== CW'(m_gen))
        $display("FAIL rand_parked cyc %0d: got %0d/%0d want %0d/%0d", m_n, res_parked, gen_parked, m_res, m_gen);
      else n_pass++;
      n_checks++;
      if (res_free !== CW'(m_cap - m_res) || gen_free !== CW'(700 - m_cap - m_gen))
        $display("FAIL rand_free cyc %0d: got %0d/%0d want %0d/%0d", m_n, res_free, gen_free,
                 m_cap - m_res, 700 - m_cap - m_gen);
      else n_pass++;
      n_checks++;
      if (hour !== 5'(m_hour())) $display("FAIL rand_hour cyc %0d: got %0d want %0d", m_n, hour, m_hour());
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    step(2'b11, 2'b10, '0, '0);
    entry_valid = 2'b11; entry_is_res = 2'b11;
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({res_parked, gen_parked} !== 20'd0 || hour !== 5'd8 || entry_grant !== 2'b00 || res_free !== 10'd500)
      $display("FAIL reset_mid_async: got res=%0d gen=%0d hour=%0d eg=%b rfree=%0d want 0/0/8/00/500",
               res_parked, gen_parked, hour, entry_grant, res_free);
    else n_pass++;
    entry_valid = '0;
    #1;
    reset = 1'b1;
    model_reset();
    step('0, '0, '0, '0);
    n_checks++;
    if ({res_parked, gen_parked} !== 20'd0 || entry_grant !== 2'b00)
      $display("FAIL reset_mid_dropped: got %0d/%0d eg=%b want 0/0/00", res_parked, gen_parked, entry_grant);
    else n_pass++;
  endtask

  task automatic test_schedule();
    @(posedge clock); #1;
    do_reset();
    for (int i = 0; i < 240; i++) step(2'b11, 2'b11, '0, '0);
    n_checks++;
    if (res_parked !== 10'd480) $display("FAIL sched_setup: got %0d want 480", res_parked); else n_pass++;
    while (m_n < 8 * CPH - 1) step('0, '0, '0, '0);
    step('0, '0, '0, '0);
    n_checks++;
    if (hour !== 5'd16 || res_parked !== 10'd200 || gen_parked !== 10'd280)
      $display("FAIL sched_hour16: got hour=%0d res=%0d gen=%0d want 16/200/280", hour, res_parked, gen_parked);
    else n_pass++;
    n_checks++;
    if (res_free !== 10'd0 || gen_free !== 10'd220)
      $display("FAIL sched_free16: got %0d/%0d want 0/220", res_free, gen_free); else n_pass++;
    test_random(24 * CPH - 1 - m_n);
    // Rollover cycle: requests act on cleared counts.
    step(2'b01, 2'b01, 2'b10, 2'b00);
    n_checks++;
    if (hour !== 5'd8 || res_parked !== 10'd1 || gen_parked !== 10'd0)
      $display("FAIL rollover_counts: got hour=%0d res=%0d gen=%0d want 8/1/0", hour, res_parked, gen_parked);
    else n_pass++;
    n_checks++;
    if (entry_grant !== 2'b01 || exit_grant !== 2'b00 || faulty_exit !== 1'b1 || res_free !== 10'd499)
      $display("FAIL rollover_grants: got eg=%b xg=%b fx=%b rfree=%0d want 01/00/1/499",
               entry_grant, exit_grant, faulty_exit, res_free);
    else n_pass++;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_faulty_exit();
    test_fill_reserved();
    test_same_cycle_full();
    test_contention();
    test_random(300);
    test_reset_mid();
    test_random(200);
    test_schedule();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
